mem_ctrl_arb: RTL and testbench

//  Byte-serial RAM/IO controller: arbitrates instruction-fetch (IF) and data (D) clients onto the single 8-bit memory port.
//  IF burst width is parametrised for cache-line fill, with abort. D does 1/2/4-byte little-endian reads and writes.
//  IO writes are throttled by io_buffer_full. Sits between icache / load-store buffer and the top-level memory pins.

---
 rtl/mem_ctrl_arb_pkg.sv | 30 +++
 rtl/mem_ctrl_arb_mem_arb.sv | 70 +++++++
 rtl/mem_ctrl_arb.sv | 184 ++++++++++++++++++
 tb/tb_mem_ctrl_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_arb_pkg.sv
// Package: mem_ctrl_arb_pkg
// Shared constants for the byte-serial memory controller and its arbiter:
// FSM state codes, data-access size codes, the default IO window base and
// a helper that turns a size code into a byte count.
package mem_ctrl_arb_pkg;

    // FSM state codes
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IF_RD = 2'd1;
    localparam logic [1:0] ST_D_RD  = 2'd2;
    localparam logic [1:0] ST_D_WR  = 2'd3;

    // Data access size codes (code 3 behaves like a 4-byte access)
    localparam logic [1:0] SZ_1B = 2'd0;
    localparam logic [1:0] SZ_2B = 2'd1;
    localparam logic [1:0] SZ_4B = 2'd2;

    // Addresses at or above this value are IO space
    localparam int unsigned IO_BASE_DEFAULT = 32'h0003_0000;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_1B:   return 3'd1;
            SZ_2B:   return 3'd2;
            SZ_4B:   return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb_mem_arb.sv
// Module: mem_arb
// Request qualification and grant selection for the memory controller.
// Data (D) normally wins; instruction fetch (IF) is forced through once D
// has been granted STARVE_LIM times in a row while IF was waiting. A store
// into IO space is held back while the IO sink reports full, letting IF use
// the port in the meantime.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   rdy             global enable; counter and grants frozen when 0
//   idle            controller FSM is in IDLE and can accept a grant
//   if_req/if_abort fetch request and its cancel
//   d_req/d_we      data request, 1 = store
//   d_addr          data address (for the IO window test)
//   io_buffer_full  IO sink cannot accept a write
//   grant_if/grant_d one-hot grant, only asserted in idle with rdy
module mem_arb
    import mem_ctrl_arb_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int unsigned IO_BASE    = IO_BASE_DEFAULT,
    parameter int          STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              idle,
    input  logic              if_req,
    input  logic              if_abort,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              io_buffer_full,
    output logic              grant_if,
    output logic              grant_d
);

    localparam int                SC_W  = $clog2(STARVE_LIM + 1);
    localparam logic [SC_W-1:0]   LIM   = SC_W'(STARVE_LIM);
    localparam logic [ADDR_W-1:0] IO_LO = ADDR_W'(IO_BASE);

    logic [SC_W-1:0] starve_cnt;
    logic            io_blocked;
    logic            if_ok;
    logic            d_ok;
    logic            force_if;

    always_comb begin
        io_blocked = d_we && (d_addr >= IO_LO) && io_buffer_full;
        // An abort in the same cycle as the request cancels the IF grant only
        if_ok      = if_req && !if_abort;
        d_ok       = d_req && !io_blocked;
        force_if   = if_ok && (starve_cnt == LIM);
        grant_if   = rdy && idle && if_ok && (!d_ok || force_if);
        grant_d    = rdy && idle && d_ok && !force_if;
    end

    // Counts D grants taken while IF was waiting; saturates at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (rdy) begin
            if (!if_req || grant_if) begin
                starve_cnt <= '0;
            end else if (grant_d && (starve_cnt != LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl_arb.sv
// Module: mem_ctrl_arb
// Byte-serial RAM/IO controller. Arbitrates the instruction-fetch client
// (IF, IF_BYTES-byte line fills) and the data client (D, 1/2/4-byte
// little-endian loads and stores) onto one 8-bit memory port.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   rdy               global enable; 0 freezes every register, mem_wr forced 0
//   mem_din           read byte for the address presented in the ending cycle
//   io_buffer_full    IO sink cannot accept a write
//   mem_dout/mem_a/mem_wr  memory port: write byte, byte address, write strobe
//   if_req/if_addr    fetch request (level) and line-aligned address
//   if_abort          cancels a pending or in-flight fetch
//   if_valid/if_data  1-cycle pulse with the completed line, byte 0 in [7:0]
//   d_req/d_we/d_size/d_addr/d_wdata  data request (level), store flag,
//                     size code, address, store data LSB first
//   d_done/d_rdata    1-cycle completion pulse, zero-extended load data
//   busy              FSM not in IDLE
// Handshake: a client holds req (and its address/data) high until it sees
// its single-cycle if_valid/d_done pulse, and drops req in that same cycle;
// a req still high at the following edge is taken as a new request.
module mem_ctrl_arb
    import mem_ctrl_arb_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          IF_BYTES   = 4,
    parameter int unsigned IO_BASE    = IO_BASE_DEFAULT,
    parameter int          STARVE_LIM = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic [7:0]            mem_din,
    input  logic                  io_buffer_full,
    output logic [7:0]            mem_dout,
    output logic [ADDR_W-1:0]     mem_a,
    output logic                  mem_wr,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_abort,
    output logic                  if_valid,
    output logic [IF_BYTES*8-1:0] if_data,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_done,
    output logic [31:0]           d_rdata,
    output logic                  busy
);

    localparam int CNT_W = $clog2(IF_BYTES);
    localparam int IF_W  = IF_BYTES * 8;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic             is_last;
    logic             idle;
    logic             grant_if;
    logic             grant_d;
    logic             mem_wr_q;
    logic [31:0]      wdata_q;
    logic [IF_W-1:0]  line_buf;
    logic [IF_W-1:0]  line_next;
    logic [31:0]      d_buf;
    logic [31:0]      d_next;
    logic [CNT_W+2:0] line_lo;
    logic [4:0]       word_lo;

    assign idle     = (state == ST_IDLE);
    assign busy     = !idle;
    assign is_last  = (cnt == last);
    assign mem_wr   = mem_wr_q & rdy;
    // Store data is shifted down one byte per written byte
    assign mem_dout = wdata_q[7:0];

    mem_arb #(
        .ADDR_W    (ADDR_W),
        .IO_BASE   (IO_BASE),
        .STARVE_LIM(STARVE_LIM)
    ) u_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy           (rdy),
        .idle          (idle),
        .if_req        (if_req),
        .if_abort      (if_abort),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .io_buffer_full(io_buffer_full),
        .grant_if      (grant_if),
        .grant_d       (grant_d)
    );

    // Buffers with the byte arriving at this edge merged in at position cnt
    always_comb begin
        line_lo   = {cnt, 3'b000};
        word_lo   = {cnt[1:0], 3'b000};
        line_next = line_buf;
        line_next[line_lo +: 8] = mem_din;
        d_next    = d_buf;
        d_next[word_lo +: 8] = mem_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            last     <= '0;
            mem_a    <= '0;
            mem_wr_q <= 1'b0;
            wdata_q  <= '0;
            line_buf <= '0;
            d_buf    <= '0;
            if_data  <= '0;
            d_rdata  <= '0;
            if_valid <= 1'b0;
            d_done   <= 1'b0;
        end else if (rdy) begin
            if_valid <= 1'b0;
            d_done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (grant_if) begin
                        state <= ST_IF_RD;
                        mem_a <= if_addr;
                        last  <= CNT_W'(IF_BYTES - 1);
                    end else if (grant_d) begin
                        state    <= d_we ? ST_D_WR : ST_D_RD;
                        mem_a    <= d_addr;
                        last     <= CNT_W'(size_bytes(d_size) - 3'd1);
                        wdata_q  <= d_wdata;
                        mem_wr_q <= d_we;
                        // Cleared so short loads come out zero-extended
                        d_buf    <= '0;
                    end
                end
                ST_IF_RD: begin
                    if (if_abort) begin
                        // Partial line stays in line_buf; if_data untouched
                        state <= ST_IDLE;
                    end else begin
                        line_buf <= line_next;
                        if (is_last) begin
                            state    <= ST_IDLE;
                            if_data  <= line_next;
                            if_valid <= 1'b1;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            mem_a <= mem_a + 1'b1;
                        end
                    end
                end
                ST_D_RD: begin
                    d_buf <= d_next;
                    if (is_last) begin
                        state   <= ST_IDLE;
                        d_rdata <= d_next;
                        d_done  <= 1'b1;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        mem_a <= mem_a + 1'b1;
                    end
                end
                ST_D_WR: begin
                    if (is_last) begin
                        state    <= ST_IDLE;
                        mem_wr_q <= 1'b0;
                        d_done   <= 1'b1;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        mem_a   <= mem_a + 1'b1;
                        wdata_q <= {8'h00, wdata_q[31:8]};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Testbench: tb_mem_ctrl_arb
// Directed scenarios for mem_ctrl_arb with a small byte memory model. Client
// tasks push expected responses into queues; a monitor pops and compares on
// every if_valid, d_done and mem_wr.
`timescale 1ns/1ps
module tb_mem_ctrl_arb;

    localparam int ADDR_W     = 32;
    localparam int IF_BYTES   = 4;
    localparam int STARVE_LIM = 4;
    localparam int IF_W       = IF_BYTES * 8;

    // ---------------- clock / reset / DUT signals ----------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rdy = 1'b1;
    logic [7:0]        mem_din;
    logic              io_buffer_full = 1'b0;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_abort = 1'b0;
    logic              if_valid;
    logic [IF_W-1:0]   if_data;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [1:0]        d_size = 2'd0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [31:0]       d_wdata = '0;
    logic              d_done;
    logic [31:0]       d_rdata;
    logic              busy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_ctrl_arb #(
        .ADDR_W    (ADDR_W),
        .IF_BYTES  (IF_BYTES),
        .IO_BASE   (32'h0003_0000),
        .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy           (rdy),
        .mem_din       (mem_din),
        .io_buffer_full(io_buffer_full),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_abort      (if_abort),
        .if_valid      (if_valid),
        .if_data       (if_data),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_size        (d_size),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_done        (d_done),
        .d_rdata       (d_rdata),
        .busy          (busy)
    );

    // ---------------- memory model ----------------
    // mem_din reflects the address presented in the cycle being sampled.
    logic [7:0] mem [0:1023];
    assign mem_din = mem[mem_a[9:0]];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem['h100] = 8'h11; mem['h101] = 8'h22; mem['h102] = 8'h33; mem['h103] = 8'h44;
        mem['h200] = 8'hAA; mem['h201] = 8'hBB;
        mem['h300] = 8'h55; mem['h301] = 8'h66; mem['h302] = 8'h77; mem['h303] = 8'h88;
        mem['h3FF] = 8'h5A; mem['h000] = 8'hC3;
        forever begin
            @(posedge clk);
            if (mem_wr && (mem_a < 32'h0003_0000)) mem[mem_a[9:0]] = mem_dout;
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [IF_W-1:0] exp_if_q[$];
    logic [32:0]     exp_d_q[$];   // {is_load, rdata}
    logic [39:0]     exp_wr_q[$];  // {addr, byte}
    int if_seen = 0;
    int d_seen  = 0;
    int wr_seen = 0;
    int d_at_if = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [IF_W-1:0] e_if;
        logic [32:0]     e_d;
        logic [39:0]     e_wr;
        forever begin
            @(negedge clk);
            if (if_valid) begin
                if_seen++;
                d_at_if = d_seen;
                if (exp_if_q.size() == 0) begin
                    check("unexpected_if_valid", 64'(if_valid), 64'd0);
                end else begin
                    e_if = exp_if_q.pop_front();
                    check("if_data", 64'(if_data), 64'(e_if));
                end
            end
            if (d_done) begin
                d_seen++;
                if (exp_d_q.size() == 0) begin
                    check("unexpected_d_done", 64'(d_done), 64'd0);
                end else begin
                    e_d = exp_d_q.pop_front();
                    if (e_d[32]) check("d_rdata", 64'(d_rdata), 64'(e_d[31:0]));
                end
            end
            if (mem_wr) begin
                wr_seen++;
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_mem_wr", {mem_a, mem_dout}, 64'd0);
                end else begin
                    e_wr = exp_wr_q.pop_front();
                    check("mem_write_addr_data", {mem_a, mem_dout}, 64'(e_wr));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic if_fetch(input logic [31:0] a, input logic [IF_W-1:0] e, output int lat);
        int start;
        bit got;
        exp_if_q.push_back(e);
        if_addr = a;
        if_req  = 1'b1;
        start   = cyc;
        got     = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (if_valid) got = 1'b1;
        end
        if_req = 1'b0;
        lat    = cyc - start;
        check("if_fetch_handshake", 64'(got), 64'd1);
    endtask

    task automatic d_access(input logic we, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_rd, output int lat);
        int start;
        int n;
        bit got;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (we) begin
            for (int k = 0; k < n; k++) exp_wr_q.push_back({a + 32'(k), wd[8*k +: 8]});
        end
        exp_d_q.push_back({!we, exp_rd});
        d_we    = we;
        d_size  = sz;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        start   = cyc;
        got     = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (d_done) got = 1'b1;
        end
        d_req = 1'b0;
        lat   = cyc - start;
        check("d_access_handshake", 64'(got), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_wr"},   64'(mem_wr),   64'd0);
        check({tag, "_mem_a"},    64'(mem_a),    64'd0);
        check({tag, "_mem_dout"}, 64'(mem_dout), 64'd0);
        check({tag, "_if_valid"}, 64'(if_valid), 64'd0);
        check({tag, "_if_data"},  64'(if_data),  64'd0);
        check({tag, "_d_done"},   64'(d_done),   64'd0);
        check({tag, "_d_rdata"},  64'(d_rdata),  64'd0);
        check({tag, "_busy"},     64'(busy),     64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat_if;
        int lat_d;
        int base;
        int base_d;
        int i;
        bit got;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // IF only: line at 0x100, valid 5 cycles after request
        @(posedge clk); #1;
        if_fetch(32'h100, 32'h4433_2211, lat_if);
        check("if_only_latency", 64'(lat_if), 64'd5);

        // Contention: D (2B load) first, then IF
        @(posedge clk); #1;
        fork
            if_fetch(32'h300, 32'h8877_6655, lat_if);
            d_access(1'b0, 2'd1, 32'h200, 32'h0, 32'h0000_BBAA, lat_d);
        join
        check("contention_d_latency", 64'(lat_d), 64'd3);
        check("contention_if_latency", 64'(lat_if), 64'd8);

        // IO throttle: store blocked for 3 cycles, then exactly one write
        @(posedge clk); #1;
        base = wr_seen;
        io_buffer_full = 1'b1;
        fork
            d_access(1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041, 32'h0, lat_d);
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("io_full_no_write", 64'(wr_seen - base), 64'd0);
                check("io_full_not_busy", 64'(busy), 64'd0);
                @(posedge clk); #1;
                io_buffer_full = 1'b0;
            end
        join
        check("io_write_count", 64'(wr_seen - base), 64'd1);
        check("io_latency", 64'(lat_d), 64'd5);

        // Starvation: IF forced after exactly STARVE_LIM D grants
        @(posedge clk); #1;
        base_d = d_seen;
        fork
            if_fetch(32'h100, 32'h4433_2211, lat_if);
            begin
                d_we = 1'b0; d_size = 2'd0; d_addr = 32'h200; d_req = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    exp_d_q.push_back({1'b1, 32'h0000_00AA});
                    got = 1'b0;
                    for (i = 0; i < 80 && !got; i++) begin
                        @(negedge clk);
                        if (d_done) got = 1'b1;
                    end
                    check("starve_d_handshake", 64'(got), 64'd1);
                end
                d_req = 1'b0;
            end
        join
        check("starve_d_grants_before_if", 64'(d_at_if - base_d), 64'd4);
        check("starve_if_latency", 64'(lat_if), 64'd13);

        // Abort during byte 2 of a fetch: no if_valid, if_data unchanged
        @(posedge clk); #1;
        base = if_seen;
        if_addr = 32'h100;
        if_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_byte2_addr", 64'(mem_a), 64'h102);
        if_abort = 1'b1;
        if_req   = 1'b0;
        @(posedge clk); #1;
        if_abort = 1'b0;
        check("abort_back_to_idle", 64'(busy), 64'd0);
        repeat (6) @(negedge clk);
        check("abort_no_if_valid", 64'(if_seen - base), 64'd0);
        check("abort_if_data_kept", 64'(if_data), 64'h4433_2211);

        // rdy=0 for 2 cycles in the middle of a 4B store
        @(posedge clk); #1;
        base = wr_seen;
        fork
            d_access(1'b1, 2'd2, 32'h180, 32'h0403_0201, 32'h0, lat_d);
            begin
                repeat (2) @(posedge clk);
                #1;
                rdy = 1'b0;
                @(negedge clk);
                check("stall_mem_wr_low_1", 64'(mem_wr), 64'd0);
                check("stall_addr_held", 64'(mem_a), 64'h181);
                @(negedge clk);
                check("stall_mem_wr_low_2", 64'(mem_wr), 64'd0);
                @(posedge clk); #1;
                rdy = 1'b1;
            end
        join
        check("stall_write_count", 64'(wr_seen - base), 64'd4);
        check("stall_store_latency", 64'(lat_d), 64'd7);

        // Read back with size code 3 (treated as 4 bytes)
        @(posedge clk); #1;
        d_access(1'b0, 2'd3, 32'h180, 32'h0, 32'h0403_0201, lat_d);
        check("readback_latency", 64'(lat_d), 64'd5);

        // Address wrap: 2B load at the top of the address space
        @(posedge clk); #1;
        d_access(1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 32'h0000_C35A, lat_d);

        // Async reset in the middle of an IF burst, then a fresh fetch
        @(posedge clk); #1;
        if_addr = 32'h100;
        if_req  = 1'b1;
        @(posedge clk); @(posedge clk); #3;
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midburst_reset");
        if_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        if_fetch(32'h100, 32'h4433_2211, lat_if);
        check("post_reset_if_latency", 64'(lat_if), 64'd5);

        // Every expectation consumed
        repeat (3) @(negedge clk);
        check("exp_if_q_empty", 64'(exp_if_q.size()), 64'd0);
        check("exp_d_q_empty",  64'(exp_d_q.size()),  64'd0);
        check("exp_wr_q_empty", 64'(exp_wr_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
